hazard_ctrl: RTL and testbench

//  Hazard/forwarding unit for the 5-stage pipeline; counterpart to the stage-control

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/forwarding unit with a data-memory ready/timeout FSM
// and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcEb0,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallEMW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              mem_err_n;
  logic [CNT_W-1:0]  stall_cnt_n, flush_cnt_n;
  logic              lw_stall, mem_hold;

  // M-stage result wins over W-stage; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rd_m,
    input logic             wr_m,
    input logic [REG_W-1:0] rd_w,
    input logic             wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (wr_m && (rs == rd_m))      sel = 2'b10;
      else if (wr_w && (rs == rd_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection; flushes are deferred while the memory holds the pipe.
  always_comb begin
    lw_stall  = ResultSrcEb0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    mem_hold  = ((state != ERR) && MemReqM && !MemReadyM) || (state == ERR);
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallEMW  = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      StallF    = lw_stall || mem_hold;
      StallD    = lw_stall || mem_hold;
      StallEMW  = mem_hold;
      FlushD    = PCSrcE && !mem_hold;
      FlushE    = (lw_stall || PCSrcE) && !mem_hold;
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end
  end

  // Memory wait FSM next state plus saturating event counters.
  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    stall_cnt_n = StallCnt;
    flush_cnt_n = FlushCnt;
    case (state)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          state_n    = MEM_WAIT;
          wait_cnt_n = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_n    = IDLE;
          wait_cnt_n = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          state_n = ERR;
        end else begin
          wait_cnt_n = wait_cnt + WAIT_W'(1);
        end
      end
      ERR: begin
        state_n = ERR;
      end
      default: begin
        state_n    = IDLE;
        wait_cnt_n = '0;
      end
    endcase
    mem_err_n = MemErr || (state_n == ERR);
    if (StallF && (StallCnt != '1)) stall_cnt_n = StallCnt + CNT_W'(1);
    if (FlushE && (FlushCnt != '1)) flush_cnt_n = FlushCnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      MemErr   <= mem_err_n;
      StallCnt <= stall_cnt_n;
      FlushCnt <= flush_cnt_n;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed multi-cycle sequences,
// and random stimulus against a behavioural model.
module tb_hazard_ctrl;

  localparam int TO = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcEb0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic StallF, StallD, StallEMW, FlushD, FlushE, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCnt, FlushCnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallEMW(StallEMW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       ld, pcsrc, wm, ww;
    logic [1:0] fa, fb;
    logic       stf, fd, fe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcEb0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural reference: miss age counts cycles of an outstanding unready access.
  bit m_err;
  int m_age, m_scnt, m_fcnt;

  function automatic logic [1:0] ref_fwd(logic [4:0] rs, logic [4:0] rdm, logic wm,
                                         logic [4:0] rdw, logic ww);
    if (rs == 0) return 2'd0;
    if (wm && rs == rdm) return 2'd2;
    if (ww && rs == rdw) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_cycle();
    bit lw, hold, e_stf, e_fd, e_fe;
    logic [1:0] e_fa, e_fb;
    if (reset) begin
      m_err = 0; m_age = 0; m_scnt = 0; m_fcnt = 0;
    end
    lw   = ResultSrcEb0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    hold = m_err || (MemReqM && !MemReadyM);
    e_stf = lw || hold;
    e_fd  = PCSrcE && !hold;
    e_fe  = (lw || PCSrcE) && !hold;
    e_fa  = ref_fwd(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    e_fb  = ref_fwd(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    if (reset) begin
      e_stf = 0; e_fd = 0; e_fe = 0; hold = 0; e_fa = 0; e_fb = 0;
    end
    chk("rnd_ForwardAE", 32'(ForwardAE), 32'(e_fa));
    chk("rnd_ForwardBE", 32'(ForwardBE), 32'(e_fb));
    chk("rnd_StallF", 32'(StallF), 32'(e_stf));
    chk("rnd_StallD", 32'(StallD), 32'(e_stf));
    chk("rnd_StallEMW", 32'(StallEMW), 32'(hold));
    chk("rnd_FlushD", 32'(FlushD), 32'(e_fd));
    chk("rnd_FlushE", 32'(FlushE), 32'(e_fe));
    chk("rnd_MemErr", 32'(MemErr), 32'(m_err));
    chk("rnd_StallCnt", 32'(StallCnt), 32'(m_scnt));
    chk("rnd_FlushCnt", 32'(FlushCnt), 32'(m_fcnt));
    if (!reset) begin
      if (e_stf && m_scnt < CMAX) m_scnt++;
      if (e_fe && m_fcnt < CMAX) m_fcnt++;
      if (!m_err) begin
        if (m_age == 0) begin
          if (MemReqM && !MemReadyM) m_age = 1;
        end else if (MemReadyM) begin
          m_age = 0;
        end else if (m_age == TO) begin
          m_err = 1;
        end else begin
          m_age++;
        end
      end
    end
  endtask

  vec_t vecs[11];

  initial begin
    //            rs1d rs2d rs1e rs2e rde rdm rdw ld pc wm ww  fa     fb    stf fd fe
    vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 1, 2'b10, 2'b00, 0, 0, 0};
    vecs[1]  = '{0, 0, 5, 0, 0, 0, 5, 0, 0, 1, 1, 2'b01, 2'b00, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 3, 0, 3, 3, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0};
    vecs[4]  = '{0, 0, 4, 4, 0, 4, 9, 0, 0, 1, 1, 2'b10, 2'b10, 0, 0, 0};
    vecs[5]  = '{7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[7]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1};
    vecs[9]  = '{0, 2, 0, 0, 2, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1, 1};
    vecs[10] = '{0, 0, 6, 0, 0, 6, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};

    // Reset forces outputs low even with hazards present on the inputs.
    clear_inputs();
    reset = 1'b1;
    Rs1E = 5; RdM = 5; RegWriteM = 1'b1; PCSrcE = 1'b1; MemReqM = 1'b1;
    #1;
    chk("rst_StallF", 32'(StallF), 0);
    chk("rst_StallEMW", 32'(StallEMW), 0);
    chk("rst_FlushE", 32'(FlushE), 0);
    chk("rst_ForwardAE", 32'(ForwardAE), 0);
    chk("rst_MemErr", 32'(MemErr), 0);
    chk("rst_StallCnt", 32'(StallCnt), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();

    // Combinational vector table, memory idle.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      ResultSrcEb0 = vecs[i].ld; PCSrcE = vecs[i].pcsrc;
      RegWriteM = vecs[i].wm; RegWriteW = vecs[i].ww;
      #1;
      chk($sformatf("vec%0d_ForwardAE", i), 32'(ForwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_ForwardBE", i), 32'(ForwardBE), 32'(vecs[i].fb));
      chk($sformatf("vec%0d_StallF", i), 32'(StallF), 32'(vecs[i].stf));
      chk($sformatf("vec%0d_StallD", i), 32'(StallD), 32'(vecs[i].stf));
      chk($sformatf("vec%0d_StallEMW", i), 32'(StallEMW), 0);
      chk($sformatf("vec%0d_FlushD", i), 32'(FlushD), 32'(vecs[i].fd));
      chk($sformatf("vec%0d_FlushE", i), 32'(FlushE), 32'(vecs[i].fe));
    end

    // Load-use stall for a single cycle.
    do_reset();
    ResultSrcEb0 = 1'b1; RdE = 7; Rs2D = 7;
    #1;
    chk("lw_StallF", 32'(StallF), 1);
    chk("lw_FlushE", 32'(FlushE), 1);
    tick();
    clear_inputs();
    #1;
    chk("lw_StallCnt", 32'(StallCnt), 1);
    chk("lw_FlushCnt", 32'(FlushCnt), 1);

    // Branch resolved while memory is stalled: flush deferred until ready.
    do_reset();
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("br_wait_FlushD", 32'(FlushD), 0);
      chk("br_wait_FlushE", 32'(FlushE), 0);
      chk("br_wait_StallEMW", 32'(StallEMW), 1);
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    chk("br_rdy_FlushD", 32'(FlushD), 1);
    chk("br_rdy_FlushE", 32'(FlushE), 1);
    chk("br_rdy_StallEMW", 32'(StallEMW), 0);

    // Timeout into the sticky error state.
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < TO; c++) tick();
    #1;
    chk("to_MemErr_early", 32'(MemErr), 0);
    tick();
    #1;
    chk("to_MemErr", 32'(MemErr), 1);
    MemReqM = 1'b0;
    #1;
    chk("to_err_StallEMW", 32'(StallEMW), 1);
    chk("to_err_StallF", 32'(StallF), 1);

    // Counter saturation.
    do_reset();
    ResultSrcEb0 = 1'b1; RdE = 7; Rs2D = 7;
    for (int c = 0; c < 20; c++) tick();
    #1;
    chk("sat_StallCnt", 32'(StallCnt), CMAX);
    chk("sat_FlushCnt", 32'(FlushCnt), CMAX);

    // Async reset in the middle of a memory wait.
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_StallEMW", 32'(StallEMW), 0);
    chk("midrst_StallF", 32'(StallF), 0);
    chk("midrst_StallCnt", 32'(StallCnt), 0);
    chk("midrst_MemErr", 32'(MemErr), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < TO; c++) tick();
    #1;
    chk("midrst_no_early_err", 32'(MemErr), 0);
    chk("midrst_StallCnt_after", 32'(StallCnt), TO);
    tick();
    #1;
    chk("midrst_err_after_full_timeout", 32'(MemErr), 1);

    // Random stimulus against the reference model.
    do_reset();
    m_err = 0; m_age = 0; m_scnt = 0; m_fcnt = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      ResultSrcEb0 = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 3) == 0);
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemReqM = ($urandom_range(0, 2) == 0);
      MemReadyM = 1'($urandom_range(0, 1));
      #1;
      model_cycle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
